elbeth_wb_arbiter: RTL and testbench
====================================

ELBETH_WB_ARBITER -- requirements
Module: elbeth_wb_arbiter

Interface
REQ-001 SHALL provide one clock and an asynchronous, active-low reset.
REQ-002 SHALL expose these ports, clock and reset first:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  pipeline writeback request; no backpressure
- a_addr  in  5  pipeline destination register
- a_data  in  32  pipeline writeback data
- b_valid  in  1  long-latency unit (load/mul/div) result valid
- b_addr  in  5  long-latency destination register
- b_data  in  32  long-latency result data
- b_ready  out  1  arbiter can accept a B result
- sb_set_valid  in  1  long-latency op issued; mark destination busy
- sb_set_addr  in  5  register to mark busy
- id_rs1_addr  in  5  decode source 1
- id_rs2_addr  in  5  decode source 2
- hazard  out  1  a decode source is busy
- stall_req  out  1  request a one-cycle pipeline bubble
- rd_addr  out  5  register-file write address
- rd_data  out  32  register-file write data
- ctrl_w_enable  out  1  register-file write enable

Function
REQ-003 SHALL arbitrate the single register-file write port between port A and a 2-entry FIFO holding accepted B results.
REQ-004 SHALL accept B on a rising edge where b_valid=1 and b_ready=1, and SHALL drive b_ready = (FIFO count < 2), independent of b_valid.
REQ-005 SHALL treat a B result with b_addr=0 as accepted, not enqueue it, and not write it.
REQ-006 SHALL give A fixed priority: an edge with a_valid=1 and a_addr!=0 SHALL register A onto the write port.
REQ-007 SHALL pop the FIFO head onto the write port only on an edge where A is not registered, i.e. a_valid=0 or a_addr=0.
REQ-008 SHALL use registered outputs: a request selected at edge N appears on rd_addr/rd_data with ctrl_w_enable=1 for exactly the cycle after edge N.
REQ-009 SHALL drive ctrl_w_enable=0 and hold rd_addr/rd_data at their previous values in cycles with no selected request.
REQ-010 SHALL allow push and pop on the same edge; with count=1, count stays 1 and FIFO order is preserved.
REQ-011 SHALL run a 2-bit age counter:
- increments on each edge where the FIFO is non-empty and the head is not popped
- clears on pop or when the FIFO is empty
- saturates at 3
REQ-012 SHALL drive stall_req=1 combinationally while the age counter is 3.
REQ-013 SHALL keep A priority even when stall_req=1 and A is still valid; stall_req stays high until the head pops.
REQ-014 SHALL keep a 32-bit busy scoreboard:
- sb_set_valid with sb_set_addr!=0 sets busy[sb_set_addr]
- popping a B entry clears busy[its addr]
- if set and clear hit the same address on one edge, set wins
- A writes never modify busy
REQ-015 SHALL drive hazard = (id_rs1_addr!=0 and busy[id_rs1_addr]) or (id_rs2_addr!=0 and busy[id_rs2_addr]), combinationally.
REQ-016 SHALL NOT resolve WAW between A and a busy register; upstream hazard stalls guarantee absence.

Reset
REQ-017 SHALL, while rst_n=0, asynchronously clear the FIFO (count 0), age counter, busy vector, rd_addr, rd_data and ctrl_w_enable, giving b_ready=1, hazard=0, stall_req=0.
REQ-018 SHALL discard in-flight FIFO entries and pending writes on reset mid-operation; no write occurs in the cycle after reset release unless selected at that edge.

Verification
REQ-019 SHALL cover: reset, then A (addr 5, data 0x11) at edge 1 -> ctrl_w_enable=1, rd_addr=5, rd_data=0x11 in cycle after edge 1 only.
REQ-020 SHALL cover: A valid every cycle plus B (addr 7, data 0xAB) -> B enqueued; stall_req rises after 3 blocked edges; A drops one cycle -> addr 7 written, stall_req=0, b_ready=1.
REQ-021 SHALL cover: three consecutive B pushes with A busy -> b_ready=0 after second; third held until pop; write order preserved.
REQ-022 SHALL cover: sb_set addr 9, id_rs1_addr=9 -> hazard=1; B addr 9 popped -> hazard=0 next cycle; set and pop of addr 9 on same edge -> busy stays 1.
REQ-023 SHALL cover: A with a_addr=0 and B with b_addr=0 -> no write, b_ready unaffected, head pops that edge.
REQ-024 SHALL cover: rst_n low with 2 FIFO entries and busy bits set -> all outputs zero, b_ready=1 immediately, no write after release.

Source files
------------

// File: rtl/elbeth_wb_arbiter.sv
// Writeback arbiter: pipeline port A has fixed priority over a 2-deep queue
// of long-latency results, with a busy scoreboard for decode hazards.
module elbeth_wb_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_valid,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   input  logic [4:0]  b_addr,
   input  logic [31:0] b_data,
   output logic        b_ready,
   input  logic        sb_set_valid,
   input  logic [4:0]  sb_set_addr,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   output logic        hazard,
   output logic        stall_req,
   output logic [4:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        ctrl_w_enable
);

   logic [1:0]  cnt_q, cnt_d;
   logic [4:0]  addr0_q, addr0_d, addr1_q, addr1_d;
   logic [31:0] data0_q, data0_d, data1_q, data1_d;
   logic [1:0]  age_q, age_d;
   logic [31:0] busy_q, busy_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        we_q, we_d;

   logic a_sel, push, pop;

   assign b_ready   = (cnt_q != 2'd2);
   assign a_sel     = a_valid && (a_addr != 5'd0);
   // zero-destination B results are consumed without occupying a slot
   assign push      = b_valid && b_ready && (b_addr != 5'd0);
   assign pop       = !a_sel && (cnt_q != 2'd0);
   assign stall_req = (age_q == 2'd3);
   assign hazard    = ((id_rs1_addr != 5'd0) && busy_q[id_rs1_addr]) ||
                      ((id_rs2_addr != 5'd0) && busy_q[id_rs2_addr]);

   assign rd_addr       = rd_addr_q;
   assign rd_data       = rd_data_q;
   assign ctrl_w_enable = we_q;

   always_comb begin
      cnt_d   = cnt_q;
      addr0_d = addr0_q;
      data0_d = data0_q;
      addr1_d = addr1_q;
      data1_d = data1_q;
      if (pop) begin
         addr0_d = addr1_q;
         data0_d = data1_q;
         cnt_d   = cnt_q - 2'd1;
      end
      if (push) begin
         if (cnt_d == 2'd0) begin
            addr0_d = b_addr;
            data0_d = b_data;
         end else begin
            addr1_d = b_addr;
            data1_d = b_data;
         end
         cnt_d = cnt_d + 2'd1;
      end
   end

   always_comb begin
      age_d = age_q;
      if (pop || (cnt_q == 2'd0)) begin
         age_d = 2'd0;
      end else if (age_q != 2'd3) begin
         age_d = age_q + 2'd1;
      end
   end

   // set is applied after clear so a same-edge set wins
   always_comb begin
      busy_d = busy_q;
      if (pop) begin
         busy_d[addr0_q] = 1'b0;
      end
      if (sb_set_valid && (sb_set_addr != 5'd0)) begin
         busy_d[sb_set_addr] = 1'b1;
      end
   end

   always_comb begin
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      we_d      = 1'b0;
      if (a_sel) begin
         rd_addr_d = a_addr;
         rd_data_d = a_data;
         we_d      = 1'b1;
      end else if (pop) begin
         rd_addr_d = addr0_q;
         rd_data_d = data0_q;
         we_d      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= 2'd0;
         addr0_q   <= 5'd0;
         data0_q   <= 32'd0;
         addr1_q   <= 5'd0;
         data1_q   <= 32'd0;
         age_q     <= 2'd0;
         busy_q    <= 32'd0;
         rd_addr_q <= 5'd0;
         rd_data_q <= 32'd0;
         we_q      <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         addr0_q   <= addr0_d;
         data0_q   <= data0_d;
         addr1_q   <= addr1_d;
         data1_q   <= data1_d;
         age_q     <= age_d;
         busy_q    <= busy_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
         we_q      <= we_d;
      end
   end

endmodule

// File: tb/tb_elbeth_wb_arbiter.sv
// Directed self-checking bench for elbeth_wb_arbiter.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_elbeth_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_valid, b_valid, sb_set_valid;
   logic [4:0]  a_addr, b_addr, sb_set_addr, id_rs1_addr, id_rs2_addr;
   logic [31:0] a_data, b_data;
   logic        b_ready, hazard, stall_req, ctrl_w_enable;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   elbeth_wb_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a_valid      (a_valid),
      .a_addr       (a_addr),
      .a_data       (a_data),
      .b_valid      (b_valid),
      .b_addr       (b_addr),
      .b_data       (b_data),
      .b_ready      (b_ready),
      .sb_set_valid (sb_set_valid),
      .sb_set_addr  (sb_set_addr),
      .id_rs1_addr  (id_rs1_addr),
      .id_rs2_addr  (id_rs2_addr),
      .hazard       (hazard),
      .stall_req    (stall_req),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .ctrl_w_enable(ctrl_w_enable)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input logic v, input logic [4:0] ad,
                        input logic [31:0] d);
      a_valid = v;
      a_addr  = ad;
      a_data  = d;
   endtask

   task automatic drv_b(input logic v, input logic [4:0] ad,
                        input logic [31:0] d);
      b_valid = v;
      b_addr  = ad;
      b_data  = d;
   endtask

   task automatic wr(input string tag, input logic we,
                     input logic [4:0] ad, input logic [31:0] d);
      chk({tag, "_we"}, {31'd0, ctrl_w_enable}, {31'd0, we});
      chk({tag, "_addr"}, {27'd0, rd_addr}, {27'd0, ad});
      chk({tag, "_data"}, rd_data, d);
   endtask

   initial begin
      rst_n = 1'b0;
      drv_a(1'b0, 5'd0, 32'd0);
      drv_b(1'b0, 5'd0, 32'd0);
      sb_set_valid = 1'b0;
      sb_set_addr  = 5'd0;
      id_rs1_addr  = 5'd0;
      id_rs2_addr  = 5'd0;
      #3;
      wr("rst", 1'b0, 5'd0, 32'd0);
      chk("rst_bready", {31'd0, b_ready}, 32'd1);
      chk("rst_hazard", {31'd0, hazard}, 32'd0);
      chk("rst_stall", {31'd0, stall_req}, 32'd0);
      #9 rst_n = 1'b1;
      tick();

      // single A write, visible for one cycle only
      drv_a(1'b1, 5'd5, 32'h11);
      tick();
      wr("a1", 1'b1, 5'd5, 32'h11);
      drv_a(1'b0, 5'd0, 32'd0);
      tick();
      wr("a1_hold", 1'b0, 5'd5, 32'h11);

      // B starved by A until stall, then drains
      drv_a(1'b1, 5'd3, 32'h33);
      drv_b(1'b1, 5'd7, 32'hAB);
      tick();
      drv_b(1'b0, 5'd0, 32'd0);
      chk("starve_bready", {31'd0, b_ready}, 32'd1);
      chk("starve_stall0", {31'd0, stall_req}, 32'd0);
      tick();
      tick();
      chk("starve_stall2", {31'd0, stall_req}, 32'd0);
      tick();
      chk("starve_stall3", {31'd0, stall_req}, 32'd1);
      wr("starve_a", 1'b1, 5'd3, 32'h33);
      drv_a(1'b0, 5'd0, 32'd0);
      tick();
      wr("starve_pop", 1'b1, 5'd7, 32'hAB);
      chk("starve_stall_clr", {31'd0, stall_req}, 32'd0);
      chk("starve_bready2", {31'd0, b_ready}, 32'd1);
      tick();
      chk("starve_idle_we", {31'd0, ctrl_w_enable}, 32'd0);

      // FIFO fill, backpressure, ordering
      drv_a(1'b1, 5'd4, 32'h44);
      drv_b(1'b1, 5'd10, 32'hA0);
      tick();
      chk("fill1_bready", {31'd0, b_ready}, 32'd1);
      drv_b(1'b1, 5'd11, 32'hA1);
      tick();
      chk("fill2_bready", {31'd0, b_ready}, 32'd0);
      drv_b(1'b1, 5'd12, 32'hA2);
      tick();
      chk("fill3_bready", {31'd0, b_ready}, 32'd0);
      drv_a(1'b0, 5'd0, 32'd0);
      tick();
      wr("fifo_pop10", 1'b1, 5'd10, 32'hA0);
      chk("fifo_bready", {31'd0, b_ready}, 32'd1);
      tick();
      wr("fifo_pop11", 1'b1, 5'd11, 32'hA1);
      drv_b(1'b0, 5'd0, 32'd0);
      tick();
      wr("fifo_pop12", 1'b1, 5'd12, 32'hA2);
      tick();
      chk("fifo_empty_we", {31'd0, ctrl_w_enable}, 32'd0);

      // scoreboard set / clear / set-wins
      sb_set_valid = 1'b1;
      sb_set_addr  = 5'd9;
      id_rs1_addr  = 5'd9;
      tick();
      sb_set_valid = 1'b0;
      chk("sb_rs1", {31'd0, hazard}, 32'd1);
      id_rs1_addr = 5'd0;
      id_rs2_addr = 5'd9;
      #1;
      chk("sb_rs2", {31'd0, hazard}, 32'd1);
      id_rs2_addr = 5'd0;
      #1;
      chk("sb_rs0", {31'd0, hazard}, 32'd0);
      id_rs1_addr = 5'd9;
      drv_b(1'b1, 5'd9, 32'h99);
      tick();
      drv_b(1'b0, 5'd0, 32'd0);
      chk("sb_before_pop", {31'd0, hazard}, 32'd1);
      tick();
      wr("sb_pop", 1'b1, 5'd9, 32'h99);
      chk("sb_cleared", {31'd0, hazard}, 32'd0);
      drv_a(1'b1, 5'd1, 32'h1);
      drv_b(1'b1, 5'd9, 32'h98);
      sb_set_valid = 1'b1;
      tick();
      drv_a(1'b0, 5'd0, 32'd0);
      drv_b(1'b0, 5'd0, 32'd0);
      tick();
      sb_set_valid = 1'b0;
      wr("sb_pop_set", 1'b1, 5'd9, 32'h98);
      chk("sb_set_wins", {31'd0, hazard}, 32'd1);
      tick();
      chk("sb_set_holds", {31'd0, hazard}, 32'd1);

      // zero-destination requests
      drv_a(1'b1, 5'd2, 32'h22);
      drv_b(1'b1, 5'd13, 32'h0D);
      tick();
      drv_a(1'b1, 5'd0, 32'hFFFF);
      drv_b(1'b1, 5'd0, 32'hEE);
      chk("z_bready", {31'd0, b_ready}, 32'd1);
      tick();
      wr("z_pop", 1'b1, 5'd13, 32'h0D);
      tick();
      wr("z_nowrite", 1'b0, 5'd13, 32'h0D);
      chk("z_bready2", {31'd0, b_ready}, 32'd1);
      drv_a(1'b0, 5'd0, 32'd0);
      drv_b(1'b0, 5'd0, 32'd0);

      // reset mid-operation
      drv_a(1'b1, 5'd6, 32'h66);
      drv_b(1'b1, 5'd20, 32'hB0);
      sb_set_valid = 1'b1;
      sb_set_addr  = 5'd20;
      id_rs1_addr  = 5'd20;
      tick();
      drv_b(1'b1, 5'd21, 32'hB1);
      sb_set_addr = 5'd21;
      tick();
      chk("pre_rst_bready", {31'd0, b_ready}, 32'd0);
      chk("pre_rst_hazard", {31'd0, hazard}, 32'd1);
      drv_a(1'b0, 5'd0, 32'd0);
      drv_b(1'b0, 5'd0, 32'd0);
      sb_set_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      wr("mrst", 1'b0, 5'd0, 32'd0);
      chk("mrst_bready", {31'd0, b_ready}, 32'd1);
      chk("mrst_hazard", {31'd0, hazard}, 32'd0);
      chk("mrst_stall", {31'd0, stall_req}, 32'd0);
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_we1", {31'd0, ctrl_w_enable}, 32'd0);
      tick();
      chk("post_rst_we2", {31'd0, ctrl_w_enable}, 32'd0);
      chk("post_rst_hazard", {31'd0, hazard}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
